ld_st_byte_sequencer: RTL and testbench

- Multi-cycle controller between the pipeline memory stage and a byte-wide data memory port (one byte per cycle).
- Accepts one load or store per request and sequences 1, 2 or 4 byte accesses depending on funct3.
- For loads, it assembles the bytes and applies sign or zero extension (lb/lh/lw/lbu/lhu).
- Stalls the pipeline, via req_ready, while an access is in flight.

---
 rtl/ld_st_byte_sequencer.sv | 101 ++++++++++
 tb/tb_ld_st_byte_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ld_st_byte_sequencer.sv
// ld_st_byte_sequencer: sequences RISC-V loads/stores over a byte-wide registered-read memory port
module ld_st_byte_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_we,
    output logic [7:0]               mem_wdata,
    input  logic [7:0]               mem_rdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     resp_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, LAST, RESP} state_t;
    state_t                   r_state, w_next;
    logic                     r_we;
    logic [2:0]               r_f3;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata, r_data, r_resp_data, w_full, w_ext;
    logic [1:0]               r_k, w_last_k, w_prev_k;
    logic                     r_err, w_accept, w_ok;
    assign w_ok = (req_funct3[1:0] != 2'b11)
                  && (req_we ? !req_funct3[2] : !(req_funct3[2] && req_funct3[1]))
                  && (req_funct3[1:0] == 2'b01 ? !req_addr[0] :
                      req_funct3[1:0] == 2'b10 ? req_addr[1:0] == 2'b00 : 1'b1);
    assign req_ready  = r_state == IDLE;
    assign w_accept   = req_valid && req_ready;
    assign w_last_k   = r_f3[1:0] == 2'b00 ? 2'd0 : r_f3[1:0] == 2'b01 ? 2'd1 : 2'd3;
    assign w_prev_k   = r_k - 2'd1;
    assign mem_addr   = r_addr + ADDRESS_WIDTH'(r_k);
    assign resp_valid = r_state == RESP;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_err;
    // Merge the final read byte and apply the funct3-selected extension
    always_comb begin
        w_full = r_data;
        w_full[{r_k, 3'b000} +: 8] = mem_rdata;
        w_ext = r_f3 == 3'b000 ? {{(DATA_WIDTH-8){w_full[7]}}, w_full[7:0]} :
                r_f3 == 3'b001 ? {{(DATA_WIDTH-16){w_full[15]}}, w_full[15:0]} :
                r_f3 == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, w_full[7:0]} :
                r_f3 == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, w_full[15:0]} : w_full;
    end
    // Next-state and memory-port drive; a write strobe is dropped the moment reset asserts
    always_comb begin
        w_next    = r_state;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        case (r_state)
            IDLE:   if (req_valid) w_next = w_ok ? ACCESS : RESP;
            ACCESS: begin
                mem_we    = r_we && !rst;
                mem_wdata = mem_we ? r_wdata[{r_k, 3'b000} +: 8] : 8'h00;
                if (r_k == w_last_k) w_next = LAST;
            end
            LAST:   w_next = RESP;
            RESP:   if (resp_ready) w_next = IDLE;
        endcase
    end
    // State, request latches, byte assembly and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_f3        <= 3'b000;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_k         <= 2'd0;
            r_data      <= '0;
            r_resp_data <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we        <= req_we;
                r_f3        <= req_funct3;
                r_wdata     <= req_wdata;
                r_data      <= '0;
                r_resp_data <= '0;
                r_err       <= !w_ok;
                if (w_ok) begin
                    r_addr <= req_addr;
                    r_k    <= 2'd0;
                end
            end
            if (r_state == ACCESS) begin
                if (r_k != 2'd0) r_data[{w_prev_k, 3'b000} +: 8] <= mem_rdata;
                if (r_k != w_last_k) r_k <= r_k + 2'd1;
            end
            if (r_state == LAST) r_resp_data <= r_we ? '0 : w_ext;
        end
    end
endmodule

// File: tb/tb_ld_st_byte_sequencer.sv
// tb_ld_st_byte_sequencer: vector table, corner sequences and randomized model checks
module tb_ld_st_byte_sequencer;
    logic        clk = 0, rst = 1, req_valid = 0, req_we = 0, resp_ready = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, mem_we, resp_valid, resp_err;
    logic [31:0] mem_addr, resp_data;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        pl_en = 0;
    logic [11:0] pl_addr = 0;
    logic [7:0]  pl_data = 0;
    logic [7:0]  mem [0:4095];
    int checks = 0, errors = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic        err;
        logic [31:0] data;
        int          lat;
        int          wr;
    } vec_t;
    vec_t tbl [16];

    always #5 clk = ~clk;

    ld_st_byte_sequencer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err)
    );

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[11:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 0;
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int hold, input logic err,
                                input logic [31:0] data, input int lat, input int wr);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.hold = hold;
        v.err = err; v.data = data; v.lat = lat; v.wr = wr;
        return v;
    endfunction

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         output logic err, output logic [31:0] data, output int lat, output int wr);
        int n;
        logic legal;
        logic [31:0] v;
        n = 1 << f3[1:0];
        legal = (f3[1:0] != 2'b11) && (we ? f3[2] == 1'b0 : (f3 != 3'b110));
        err = !legal || (addr % 32'(n)) != 32'd0;
        data = 0; lat = 1; wr = 0;
        if (!err) begin
            lat = n + 2;
            wr = we ? n : 0;
            if (!we) begin
                v = 0;
                for (int k = 0; k < n; k++) v = v | (32'(mem[12'(addr + 32'(k))]) << (8 * k));
                if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
                if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
                data = v;
            end
        end
    endtask

    task automatic xact(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input logic exp_err,
                        input logic [31:0] exp_data, input int exp_lat, input int exp_wr);
        int cyc, lat, wr;
        logic [31:0] a0;
        @(negedge clk);
        a0 = mem_addr;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; resp_ready = 0;
        check({nm, ":req_ready_idle"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        cyc = 0; lat = 0; wr = 0;
        while (lat == 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_we) begin
                check({nm, ":wr_addr"}, mem_addr, addr + 32'(wr));
                check({nm, ":wr_data"}, 32'(mem_wdata), 32'(8'(wdata >> (8 * wr))));
                wr++;
            end
            if (exp_err) check({nm, ":addr_unchanged"}, mem_addr, a0);
            else if (cyc <= exp_lat - 2) check({nm, ":mem_addr"}, mem_addr, addr + 32'(cyc - 1));
            check({nm, ":req_ready_busy"}, 32'(req_ready), 32'd0);
            if (resp_valid) lat = cyc;
        end
        check({nm, ":latency"}, 32'(lat), 32'(exp_lat));
        check({nm, ":resp_err"}, 32'(resp_err), 32'(exp_err));
        check({nm, ":resp_data"}, resp_data, exp_data);
        repeat (hold) begin
            @(negedge clk);
            if (mem_we) wr++;
            check({nm, ":hold_valid"}, 32'(resp_valid), 32'd1);
            check({nm, ":hold_data"}, resp_data, exp_data);
            check({nm, ":hold_err"}, 32'(resp_err), 32'(exp_err));
            check({nm, ":hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1;
        @(negedge clk);
        check({nm, ":post_valid"}, 32'(resp_valid), 32'd0);
        check({nm, ":post_req_ready"}, 32'(req_ready), 32'd1);
        check({nm, ":post_mem_we"}, 32'(mem_we), 32'd0);
        check({nm, ":write_count"}, 32'(wr), 32'(exp_wr));
        resp_ready = 0;
        req_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic [31:0] d, a;
        int          l, w;
        logic        rwe;
        logic [2:0]  rf3;

        tbl[0]  = mk(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0, 32'h1234_5678, 6, 0);
        tbl[1]  = mk(1'b0, 3'b000, 32'h201, 32'h0, 0, 1'b0, 32'hFFFF_FF80, 3, 0);
        tbl[2]  = mk(1'b0, 3'b100, 32'h201, 32'h0, 0, 1'b0, 32'h0000_0080, 3, 0);
        tbl[3]  = mk(1'b1, 3'b001, 32'h302, 32'hAABB_CCDD, 0, 1'b0, 32'h0, 4, 2);
        tbl[4]  = mk(1'b0, 3'b010, 32'h101, 32'h0, 0, 1'b1, 32'h0, 1, 0);
        tbl[5]  = mk(1'b0, 3'b011, 32'h100, 32'h0, 0, 1'b1, 32'h0, 1, 0);
        tbl[6]  = mk(1'b0, 3'b001, 32'h110, 32'h0, 5, 1'b0, 32'hFFFF_8001, 4, 0);
        tbl[7]  = mk(1'b0, 3'b101, 32'h110, 32'h0, 0, 1'b0, 32'h0000_8001, 4, 0);
        tbl[8]  = mk(1'b1, 3'b000, 32'h401, 32'h1234_5678, 1, 1'b0, 32'h0, 3, 1);
        tbl[9]  = mk(1'b1, 3'b100, 32'h400, 32'h1, 0, 1'b1, 32'h0, 1, 0);
        tbl[10] = mk(1'b0, 3'b001, 32'h111, 32'h0, 0, 1'b1, 32'h0, 1, 0);
        tbl[11] = mk(1'b1, 3'b010, 32'h500, 32'hDEAD_BEEF, 2, 1'b0, 32'h0, 6, 4);
        tbl[12] = mk(1'b0, 3'b010, 32'h500, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 6, 0);
        tbl[13] = mk(1'b0, 3'b000, 32'h401, 32'h0, 0, 1'b0, 32'h0000_0078, 3, 0);
        tbl[14] = mk(1'b1, 3'b010, 32'h502, 32'h0, 0, 1'b1, 32'h0, 1, 0);
        tbl[15] = mk(1'b0, 3'b101, 32'h302, 32'h0, 0, 1'b0, 32'h0000_CCDD, 4, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst:req_ready", 32'(req_ready), 32'd1);
        check("rst:mem_we", 32'(mem_we), 32'd0);
        check("rst:mem_addr", mem_addr, 32'd0);
        check("rst:mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst:resp_valid", 32'(resp_valid), 32'd0);
        check("rst:resp_data", resp_data, 32'd0);
        check("rst:resp_err", 32'(resp_err), 32'd0);
        rst = 0;

        poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
        poke(12'h201, 8'h80); poke(12'h110, 8'h01); poke(12'h111, 8'h80);
        for (int i = 0; i < 4; i++) poke(12'h600 + 12'(i), 8'hEE);
        for (int i = 12'h800; i < 4096; i++) poke(12'(i), 8'($urandom));

        for (int i = 0; i < 16; i++)
            xact($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
                 tbl[i].err, tbl[i].data, tbl[i].lat, tbl[i].wr);

        @(negedge clk);
        rst = 1; req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(posedge clk); #1;
        rst = 0; req_valid = 0;
        repeat (4) begin
            @(negedge clk);
            check("rst_vs_req:req_ready", 32'(req_ready), 32'd1);
            check("rst_vs_req:resp_valid", 32'(resp_valid), 32'd0);
        end

        @(negedge clk);
        req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h600; req_wdata = 32'h4433_2211;
        @(posedge clk); #1;
        req_valid = 0;
        repeat (3) @(negedge clk);
        check("midrst:third_access_we", 32'(mem_we), 32'd1);
        check("midrst:third_access_addr", mem_addr, 32'h602);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("midrst:req_ready", 32'(req_ready), 32'd1);
        check("midrst:mem_we", 32'(mem_we), 32'd0);
        repeat (4) begin
            check("midrst:resp_valid", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        check("midrst:byte0", 32'(mem[12'h600]), 32'h11);
        check("midrst:byte1", 32'(mem[12'h601]), 32'h22);
        check("midrst:byte2", 32'(mem[12'h602]), 32'hEE);
        check("midrst:byte3", 32'(mem[12'h603]), 32'hEE);
        xact("midrst:lw_after", 1'b0, 3'b010, 32'h600, 32'h0, 0, 1'b0, 32'hEEEE_2211, 6, 0);

        for (int i = 0; i < 150; i++) begin
            rwe = 1'($urandom);
            rf3 = 3'($urandom);
            a = 32'h800 + 32'($urandom_range(0, 511)) * 4
                + ($urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 3)) : 32'd0);
            model(rwe, rf3, a, e, d, l, w);
            xact($sformatf("rnd%0d", i), rwe, rf3, a, $urandom, $urandom_range(0, 2), e, d, l, w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
